// File: rtl/seq_generator_if.sv
// Load handshake and serial output bundle for seq_generator.
// The generator sits on the slave side; the pattern source or bench is the master.
interface seq_generator_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4
) ();
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] rep;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, pattern, len, rep, abort,
    input  load_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  load_valid, pattern, len, rep, abort,
    output load_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a loaded word out MSB-first, rep+1 times, then pulses done.
// Optional macro SEQ_GEN_GAP_EN inserts GAP_CYC idle cycles between repetitions.
module seq_generator #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input logic            clk,
  input logic            rst,
  seq_generator_if.slave bus
);

  if (WIDTH < 2 || (WIDTH >> LEN_W) != 0 || GAP_CYC < 1) begin : g_param_check
    $error("seq_generator: illegal parameter combination");
  end

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [GapW-1:0] gap_q, gap_d;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

  assign eff_len = (bus.len == '0 || bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
  // Left-align the active bits so the next bit to send is always the MSB.
  assign aligned = bus.pattern << (LEN_W'(WIDTH) - eff_len);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
`ifdef SEQ_GEN_GAP_EN
    gap_d   = gap_q;
`endif
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          state_d = StShift;
          pat_d   = aligned;
          len_d   = eff_len;
          rep_d   = bus.rep;
          dout_d  = aligned[WIDTH-1];
          sh_d    = aligned << 1;
          cnt_d   = eff_len - 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      StShift: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          dout_d  = sh_q[WIDTH-1];
          sh_d    = sh_q << 1;
          cnt_d   = cnt_q - 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q != '0) begin
          rep_d  = rep_q - 1'b1;
          busy_d = 1'b1;
`ifdef SEQ_GEN_GAP_EN
          state_d = StGap;
          gap_d   = GapW'(GAP_CYC - 1);
`else
          dout_d  = pat_q[WIDTH-1];
          sh_d    = pat_q << 1;
          cnt_d   = len_q - 1'b1;
          valid_d = 1'b1;
`endif
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      StGap: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (gap_q == '0) begin
          state_d = StShift;
          dout_d  = pat_q[WIDTH-1];
          sh_d    = pat_q << 1;
          cnt_d   = len_q - 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - 1'b1;
          busy_d = 1'b1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= '0;
`endif
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
`ifdef SEQ_GEN_GAP_EN
      gap_q   <= gap_d;
`endif
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready = (state_q == StIdle);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: a per-cycle expectation queue is filled from a
// reference model at load time and drained as the DUT produces output.
module tb_seq_generator;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned GC = 2;

  typedef struct packed {
    logic v;
    logic d;
    logic dn;
    logic b;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  seq_generator_if #(.WIDTH(W), .LEN_W(LW), .CNT_W(CW)) bus ();

  seq_generator #(
    .WIDTH  (W),
    .LEN_W  (LW),
    .CNT_W  (CW),
    .GAP_CYC(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Reference model: one entry per output cycle, ending with the done cycle.
  function automatic void push_load(input logic [W-1:0] p, input logic [LW-1:0] ln,
                                    input logic [CW-1:0] rp);
    int l;
    exp_t e;
    l = (ln == 0 || int'(ln) > int'(W)) ? int'(W) : int'(ln);
    for (int r = 0; r <= int'(rp); r++) begin
      for (int i = l - 1; i >= 0; i--) begin
        e = '{v: 1'b1, d: p[i], dn: 1'b0, b: 1'b1};
        sb.push_back(e);
      end
`ifdef SEQ_GEN_GAP_EN
      if (r < int'(rp)) begin
        for (int g = 0; g < int'(GC); g++) begin
          e = '{v: 1'b0, d: 1'b0, dn: 1'b0, b: 1'b1};
          sb.push_back(e);
        end
      end
`endif
    end
    e = '{v: 1'b0, d: 1'b0, dn: 1'b1, b: 1'b0};
    sb.push_back(e);
  endfunction

  // One clock; compare every output against the next expectation (idle when empty).
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    e = (sb.size() != 0) ? sb.pop_front() : exp_t'('0);
    chk("dout_valid", bus.dout_valid, e.v);
    chk("dout", bus.dout, e.d);
    chk("done", bus.done, e.dn);
    chk("busy", bus.busy, e.b);
    chk("load_ready", bus.load_ready, ~e.b);
  endtask

  task automatic run_load(input logic [W-1:0] p, input logic [LW-1:0] ln,
                          input logic [CW-1:0] rp, input logic ab);
    int guard;
    bus.pattern    = p;
    bus.len        = ln;
    bus.rep        = rp;
    bus.abort      = ab;
    bus.load_valid = 1'b1;
    push_load(p, ln, rp);
    cycle();
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
    bus.pattern    = '0;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      cycle();
      guard++;
    end
    cycle();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    bus.pattern    = '0;
    bus.len        = '0;
    bus.rep        = '0;
    bus.abort      = 1'b0;

    #1;
    chk("rst_dout", bus.dout, 1'b0);
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ready", bus.load_ready, 1'b1);
    #20;
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    cycle();

    run_load(8'h0A, 4'd4, 4'd0, 1'b0);
    run_load(8'hA5, 4'd0, 4'd0, 1'b0);
    run_load(8'h05, 4'd3, 4'd2, 1'b0);
    run_load(8'h3C, 4'd12, 4'd0, 1'b0);
    run_load(8'h01, 4'd1, 4'd15, 1'b0);
    // Abort together with load in idle: load wins.
    run_load(8'hB2, 4'd5, 4'd1, 1'b1);

    // load_valid held through a busy transmission with a different pattern.
    bus.pattern    = 8'hC3;
    bus.len        = 4'd8;
    bus.rep        = 4'd0;
    bus.load_valid = 1'b1;
    push_load(8'hC3, 4'd8, 4'd0);
    cycle();
    bus.pattern = 8'h81;
    bus.len     = 4'd2;
    push_load(8'h81, 4'd2, 4'd0);
    repeat (8) cycle();
    cycle();
    bus.load_valid = 1'b0;
    while (sb.size() != 0) cycle();
    cycle();

    // Abort on the third bit of an 8-bit load with a pending repetition.
    bus.pattern    = 8'h96;
    bus.len        = 4'd8;
    bus.rep        = 4'd1;
    bus.load_valid = 1'b1;
    push_load(8'h96, 4'd8, 4'd1);
    cycle();
    bus.load_valid = 1'b0;
    cycle();
    cycle();
    bus.abort = 1'b1;
    sb.delete();
    cycle();
    bus.abort = 1'b0;
    cycle();

    // Asynchronous reset between edges mid-transmission.
    bus.pattern    = 8'hFF;
    bus.len        = 4'd8;
    bus.rep        = 4'd0;
    bus.load_valid = 1'b1;
    push_load(8'hFF, 4'd8, 4'd0);
    cycle();
    bus.load_valid = 1'b0;
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dout", bus.dout, 1'b0);
    chk("arst_valid", bus.dout_valid, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_ready", bus.load_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    run_load(8'h3C, 4'd6, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
